// File: rtl/booth_pp_accum_if.sv
// Handshake/data bundle between a radix-4 digit source and booth_pp_accum.
// The err signal and its modport entries exist only when BOOTH_OP_CHECK_EN is defined.
interface booth_pp_accum_if;
  logic        start;
  logic [15:0] mcand;
  logic        dig_valid;
  logic        dig_ready;
  logic [1:0]  op;
  logic        sign;
  logic        busy;
  logic        done;
  logic [31:0] product;
`ifdef BOOTH_OP_CHECK_EN
  logic        err;

  modport master (output start, mcand, dig_valid, op, sign,
                  input  dig_ready, busy, done, product, err);
  modport slave  (input  start, mcand, dig_valid, op, sign,
                  output dig_ready, busy, done, product, err);
`else
  modport master (output start, mcand, dig_valid, op, sign,
                  input  dig_ready, busy, done, product);
  modport slave  (input  start, mcand, dig_valid, op, sign,
                  output dig_ready, busy, done, product);
`endif
endinterface

// File: rtl/booth_pp_accum.sv
// Radix-4 Booth partial-product accumulator: one recoded digit per accepted beat,
// NDIG digits per product. Optional illegal-digit flag under BOOTH_OP_CHECK_EN.
module booth_pp_accum #(
  parameter int NDIG = 8
) (
  input logic            clk,
  input logic            rst,
  booth_pp_accum_if.slave bus
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [15:0]        mcand_q;
  logic [31:0]        acc_q, acc_d;
  logic [CW-1:0]      cnt_q;
  logic [31:0]        product_q;
  logic signed [17:0] mag, pp;
  logic [31:0]        pp_ext;
  logic               accept, last;

  // 18 bits so that -(2 * -32768) = +65536 stays representable
  always_comb begin
    mag = '0;
    case (bus.op)
      2'd1:    mag = {{2{mcand_q[15]}}, mcand_q};
      2'd2:    mag = {mcand_q[15], mcand_q, 1'b0};
      default: mag = '0;
    endcase
    pp     = bus.sign ? -mag : mag;
    pp_ext = {{14{pp[17]}}, pp};
    acc_d  = acc_q + (pp_ext << {cnt_q, 1'b0});
  end

  assign accept = (state_q == ACC) && bus.dig_valid;
  assign last   = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ACC;
      ACC:     if (accept && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        mcand_q <= bus.mcand;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else if (accept) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 1'b1;
        if (last) product_q <= acc_d;
      end
    end
  end

`ifdef BOOTH_OP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                err_q <= 1'b0;
    else if (state_q == IDLE && bus.start)  err_q <= 1'b0;
    else if (accept && bus.op == 2'd3)      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`endif

  assign bus.dig_ready = (state_q == ACC);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.product   = product_q;

endmodule

// File: doc/booth_pp_accum.md
BOOTH_PP_ACCUM -- requirements
Module: booth_pp_accum

Interface
REQ-001 Parameter NDIG, default 8, meaning radix-4 digits accumulated per product (one 16-bit signed multiplier).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begin new product; sampled only in IDLE.
REQ-005 mcand  input  16  signed multiplicand A; captured on accepted start.
REQ-006 dig_valid  input  1  recoded digit present on op/sign.
REQ-007 dig_ready  output  1  block can accept a digit this cycle.
REQ-008 op  input  2  digit magnitude: 0 => 0, 1 => A, 2 => 2A, 3 => illegal.
REQ-009 sign  input  1  0 => add, 1 => subtract.
REQ-010 busy  output  1  high in ACC and DONE.
REQ-011 done  output  1  one-cycle pulse; product valid.
REQ-012 product  output  32  signed product A*B.
REQ-013 err  output  1  sticky illegal-digit flag (present only per REQ-029).

Function
REQ-014 FSM states SHALL be IDLE, ACC and DONE.
REQ-015 IDLE with start=1: capture mcand, clear accumulator and digit counter, go to ACC; start=0 stays IDLE.
REQ-016 dig_ready SHALL be 1 only in ACC; digit accepted when dig_valid and dig_ready are both 1 on a rising edge.
REQ-017 Partial product pp, 18-bit signed: op 0 => 0; 1 => sext(A); 2 => sext(A)<<1; op 3 => 0.
REQ-018 sign=1 SHALL negate pp (two's complement); sign=1 with magnitude 0 gives 0.
REQ-019 Accepted digit k (k = 0..NDIG-1, arrival order) SHALL add sext32(pp) << 2k into the 32-bit accumulator, modulo 2^32.
REQ-020 Counter increments per accepted digit; cycles with dig_valid=0 hold all state (arbitrary gaps allowed).
REQ-021 Acceptance of digit NDIG-1 SHALL move FSM to DONE and load product with the final accumulator value on that same edge.
REQ-022 In DONE: done=1 for exactly one cycle, dig_ready=0, then unconditionally to IDLE.
REQ-023 Latency: done and product valid the cycle after the last digit is accepted; minimum 1 + NDIG + 1 cycles from start to done.
REQ-024 start asserted in ACC or DONE SHALL be ignored; mcand changes after capture SHALL have no effect.
REQ-025 product SHALL hold its value from DONE until the next DONE; it SHALL NOT change on start.
REQ-026 Extreme case A = -32768 with digit -2A SHALL produce +65536 in pp without overflow (18-bit width).

Reset
REQ-027 rst=1 SHALL immediately force IDLE, product=0, accumulator=0, counter=0, done=0, busy=0, dig_ready=0, err=0, independent of clk.
REQ-028 Reset mid-ACC SHALL discard the partial result; the first start after release begins a clean product.

Configuration
REQ-029 Macro BOOTH_OP_CHECK_EN: when defined, port err exists; accepting a digit with op=3 sets err=1, held until rst or the next accepted start; the digit still contributes 0. When undefined, err port and its logic are absent; op=3 silently contributes 0.

Verification
REQ-030 A=3, digits (op,sign) = (1,0),(1,0), then 6x (0,0) [B=5] -> done one cycle after 8th digit, product=0x0000000F.
REQ-031 A=0x8000, digits 7x (0,0), then (2,1) [B=-32768] -> product=0x40000000.
REQ-032 A=7, 8x (1,0), dig_valid deasserted 3 cycles between each digit -> product=0x00025553, dig_ready high throughout ACC, done exactly one pulse.
REQ-033 rst pulsed after 4th digit, then start with A=3 and B=5 digits -> product=0x0000000F; no done before reset recovery; outputs 0 during reset.
REQ-034 start held high through ACC and DONE -> ignored until IDLE; new product begins the cycle after DONE with the new mcand.
REQ-035 With BOOTH_OP_CHECK_EN: A=5, digit0 op=3, remaining digits (0,0) -> err=1 after digit0, product=0; next accepted start clears err.
